// File: rtl/sfp_accumulator_pkg.sv
// Shared core constants for the accumulation path: array geometry, instruction
// bit positions, and the per-edge operation decode used by every lane.
package sfp_accumulator_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int LEN_KIJ = 9;
  localparam int CNT_BW  = 4;

  // Core instruction word layout.
  localparam int INST_ACC_BIT      = 33;
  localparam int INST_CEN_PMEM_BIT = 32;
  localparam int INST_WEN_PMEM_BIT = 31;
  localparam int INST_A_PMEM_MSB   = 30;
  localparam int INST_A_PMEM_LSB   = 20;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_LOAD  = 2'd2,
    OP_ACC   = 2'd3
  } acc_op_e;

  // A clear together with acc restarts the sum from the incoming term, so a
  // new burst can begin on the very cycle the old one is discarded.
  function automatic acc_op_e decode_op(input logic clear, input logic acc);
    acc_op_e op;
    op = OP_HOLD;
    if (clear && acc) begin
      op = OP_LOAD;
    end else if (clear) begin
      op = OP_CLEAR;
    end else if (acc) begin
      op = OP_ACC;
    end
    return op;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One output column: saturating signed accumulator, sticky overflow flag and a
// registered, optionally ReLU-clipped copy of the running sum.
module sfp_lane
  import sfp_accumulator_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               acc,
  input  logic               relu_en,
  input  logic [psum_bw-1:0] psum_in,
  output logic [psum_bw-1:0] sfp_out,
  output logic               overflow
);

  localparam logic [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  acc_op_e            op;
  logic [psum_bw:0]   sum_wide;
  logic               sat_hit;
  logic [psum_bw-1:0] sat_sum;

  logic [psum_bw-1:0] a_d, a_q;
  logic [psum_bw-1:0] out_d, out_q;
  logic               ovf_d, ovf_q;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    op       = decode_op(clear, acc);
    sum_wide = {a_q[psum_bw-1], a_q} + {psum_in[psum_bw-1], psum_in};
    // The two top bits of the widened sum disagree exactly when the true
    // result falls outside the psum_bw range; the top bit gives the direction.
    sat_hit  = sum_wide[psum_bw] ^ sum_wide[psum_bw-1];
    sat_sum  = sum_wide[psum_bw-1:0];
    if (sat_hit) begin
      sat_sum = sum_wide[psum_bw] ? SAT_MIN : SAT_MAX;
    end

    a_d   = a_q;
    ovf_d = ovf_q;
    case (op)
      OP_CLEAR: begin
        a_d   = '0;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        a_d   = psum_in;
        ovf_d = 1'b0;
      end
      OP_ACC: begin
        a_d   = sat_sum;
        ovf_d = ovf_q | sat_hit;
      end
      default: begin
        a_d   = a_q;
        ovf_d = ovf_q;
      end
    endcase

    // The clip is applied to the output copy only; the accumulator keeps the
    // true signed sum so toggling relu_en later re-derives the output.
    out_d = a_d;
    if (relu_en && a_d[psum_bw-1]) begin
      out_d = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign sfp_out  = out_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/sfp_accumulator.sv
// Accumulation-phase consumer of PMEM read data: col saturating lanes plus the
// shared term counter and end-of-burst valid pulse.
module sfp_accumulator
  import sfp_accumulator_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int cnt_bw  = CNT_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic                   clear,
  input  logic                   relu_en,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic [col*psum_bw-1:0] sfp_out,
  output logic                   out_valid,
  output logic [cnt_bw-1:0]      acc_cnt,
  output logic [col-1:0]         overflow
);

  acc_op_e           op;
  logic [cnt_bw-1:0] acc_cnt_d, acc_cnt_q;
  logic              acc_d_d, acc_d_q;
  logic              out_valid_d, out_valid_q;

  always_comb begin
    op        = decode_op(clear, acc);
    acc_cnt_d = acc_cnt_q;
    case (op)
      OP_CLEAR: acc_cnt_d = '0;
      OP_LOAD:  acc_cnt_d = {{(cnt_bw-1){1'b0}}, 1'b1};
      OP_ACC: begin
        if (acc_cnt_q != {cnt_bw{1'b1}}) begin
          acc_cnt_d = acc_cnt_q + 1'b1;
        end
      end
      default:  acc_cnt_d = acc_cnt_q;
    endcase

    // Falling edge of acc marks the end of a burst; clear is deliberately not
    // part of this term so a same-cycle clear cannot swallow the pulse.
    acc_d_d     = acc;
    out_valid_d = acc_d_q & ~acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q   <= '0;
      acc_d_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      acc_d_q     <= acc_d_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar c = 0; c < col; c++) begin : g_lane
    sfp_lane #(
      .psum_bw(psum_bw)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .acc     (acc),
      .relu_en (relu_en),
      .psum_in (psum_in[psum_bw*c +: psum_bw]),
      .sfp_out (sfp_out[psum_bw*c +: psum_bw]),
      .overflow(overflow[c])
    );
  end

  assign acc_cnt   = acc_cnt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sfp_accumulator.sv
// Directed bench for sfp_accumulator: reset, bursts, ReLU, saturation,
// clear/acc collision, counter saturation and merged bursts.
module tb_sfp_accumulator;

  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int CW  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                acc;
  logic                clear;
  logic                relu_en;
  logic [COL*BW-1:0]   psum_in;
  logic [COL*BW-1:0]   sfp_out;
  logic                out_valid;
  logic [CW-1:0]       acc_cnt;
  logic [COL-1:0]      overflow;

  int errors = 0;
  int checks = 0;

  sfp_accumulator #(
    .col(COL),
    .psum_bw(BW),
    .cnt_bw(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .acc      (acc),
    .clear    (clear),
    .relu_en  (relu_en),
    .psum_in  (psum_in),
    .sfp_out  (sfp_out),
    .out_valid(out_valid),
    .acc_cnt  (acc_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; results of that edge are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] lane_of(input int c);
    return sfp_out[c*BW +: BW];
  endfunction

  task automatic set_lanes(input logic [BW-1:0] v0, input logic [BW-1:0] vrest);
    for (int c = 0; c < COL; c++) psum_in[c*BW +: BW] = (c == 0) ? v0 : vrest;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    acc   = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_lanes(16'h0005, 16'h0005);
    acc = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (sfp_out !== '0) begin errors++; $display("FAIL reset_async_sfp_out got=%h exp=0", sfp_out); end
    checks++; if (acc_cnt !== '0) begin errors++; $display("FAIL reset_async_acc_cnt got=%0d exp=0", acc_cnt); end
    checks++; if (overflow !== '0) begin errors++; $display("FAIL reset_async_overflow got=%b exp=0", overflow); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_async_out_valid got=%b exp=0", out_valid); end
    acc = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (sfp_out !== '0 || acc_cnt !== '0 || out_valid !== 1'b0 || overflow !== '0) begin
      errors++;
      $display("FAIL reset_release_idle sfp=%h cnt=%0d ov=%b valid=%b exp all 0", sfp_out, acc_cnt, overflow, out_valid);
    end
  endtask

  task automatic test_burst9();
    do_clear();
    set_lanes(16'h0003, 16'h0003);
    acc = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL burst9_valid_early term=%0d got=%b exp=0", i, out_valid); end
    end
    checks++; if (acc_cnt !== 4'd9) begin errors++; $display("FAIL burst9_acc_cnt got=%0d exp=9", acc_cnt); end
    acc = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL burst9_valid_pulse got=%b exp=1", out_valid); end
    for (int c = 0; c < COL; c++) begin
      checks++; if (lane_of(c) !== 16'h001B) begin errors++; $display("FAIL burst9_lane%0d got=%h exp=001b", c, lane_of(c)); end
    end
    checks++; if (overflow !== '0) begin errors++; $display("FAIL burst9_overflow got=%b exp=0", overflow); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL burst9_valid_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_relu();
    relu_en = 1'b0;
    do_clear();
    set_lanes(16'hFFFB, 16'h0002);
    acc = 1'b1;
    repeat (9) tick();
    acc = 1'b0;
    tick();
    checks++; if (lane_of(0) !== 16'hFFD3) begin errors++; $display("FAIL relu_off_lane0 got=%h exp=ffd3", lane_of(0)); end
    checks++; if (lane_of(5) !== 16'h0012) begin errors++; $display("FAIL relu_off_lane5 got=%h exp=0012", lane_of(5)); end
    relu_en = 1'b1;
    tick();
    checks++; if (lane_of(0) !== 16'h0000) begin errors++; $display("FAIL relu_on_lane0 got=%h exp=0000", lane_of(0)); end
    for (int c = 1; c < COL; c++) begin
      checks++; if (lane_of(c) !== 16'h0012) begin errors++; $display("FAIL relu_on_lane%0d got=%h exp=0012", c, lane_of(c)); end
    end
    relu_en = 1'b0;
    tick();
    checks++; if (lane_of(0) !== 16'hFFD3) begin errors++; $display("FAIL relu_restore_lane0 got=%h exp=ffd3", lane_of(0)); end
  endtask

  task automatic test_saturation();
    do_clear();
    set_lanes(16'h0000, 16'h0000);
    psum_in[3*BW +: BW] = 16'h7000;
    acc = 1'b1;
    tick();
    checks++; if (lane_of(3) !== 16'h7000 || overflow !== 8'h00) begin
      errors++; $display("FAIL sat_term1 lane3=%h ov=%b exp=7000/00000000", lane_of(3), overflow);
    end
    tick();
    checks++; if (lane_of(3) !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_clamp got=%h exp=7fff", lane_of(3)); end
    checks++; if (overflow !== 8'h08) begin errors++; $display("FAIL sat_pos_flag got=%b exp=00001000", overflow); end
    psum_in[3*BW +: BW] = 16'h8000;
    tick();
    checks++; if (lane_of(3) !== 16'hFFFF) begin errors++; $display("FAIL sat_term3 got=%h exp=ffff", lane_of(3)); end
    acc = 1'b0;
    tick();
    checks++; if (overflow !== 8'h08) begin errors++; $display("FAIL sat_sticky got=%b exp=00001000", overflow); end
    do_clear();
    #0;
    checks++; if (overflow !== '0 || acc_cnt !== '0 || sfp_out !== '0) begin
      errors++; $display("FAIL sat_clear ov=%b cnt=%0d sfp=%h exp all 0", overflow, acc_cnt, sfp_out);
    end
  endtask

  task automatic test_clear_acc();
    do_clear();
    set_lanes(16'h0003, 16'h0003);
    acc = 1'b1;
    repeat (9) tick();
    acc = 1'b0;
    tick();
    tick();
    checks++; if (lane_of(2) !== 16'h001B) begin errors++; $display("FAIL collide_pre got=%h exp=001b", lane_of(2)); end
    clear = 1'b1;
    acc   = 1'b1;
    set_lanes(16'h0004, 16'h0004);
    tick();
    clear = 1'b0;
    acc   = 1'b0;
    for (int c = 0; c < COL; c++) begin
      checks++; if (lane_of(c) !== 16'h0004) begin errors++; $display("FAIL collide_lane%0d got=%h exp=0004", c, lane_of(c)); end
    end
    checks++; if (acc_cnt !== 4'd1) begin errors++; $display("FAIL collide_acc_cnt got=%0d exp=1", acc_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL collide_no_pulse got=%b exp=0", out_valid); end
    // The one-term burst ends now; a clear on the same edge must not hide it.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_keeps_pulse got=%b exp=1", out_valid); end
    checks++; if (sfp_out !== '0 || acc_cnt !== '0) begin errors++; $display("FAIL clear_with_pulse sfp=%h cnt=%0d exp 0", sfp_out, acc_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    do_clear();
    set_lanes(16'h0003, 16'h0003);
    acc = 1'b1;
    repeat (4) tick();
    checks++; if (lane_of(1) !== 16'h000C) begin errors++; $display("FAIL midrst_pre got=%h exp=000c", lane_of(1)); end
    #2 reset = 1'b1;
    acc = 1'b0;
    #1;
    checks++; if (sfp_out !== '0) begin errors++; $display("FAIL midrst_async got=%h exp=0", sfp_out); end
    repeat (2) tick();
    reset = 1'b0;
    acc   = 1'b1;
    repeat (5) tick();
    acc = 1'b0;
    for (int c = 0; c < COL; c++) begin
      checks++; if (lane_of(c) !== 16'h000F) begin errors++; $display("FAIL midrst_lane%0d got=%h exp=000f", c, lane_of(c)); end
    end
    checks++; if (acc_cnt !== 4'd5) begin errors++; $display("FAIL midrst_acc_cnt got=%0d exp=5", acc_cnt); end
    tick();
  endtask

  task automatic test_cnt_saturation();
    do_clear();
    set_lanes(16'h0001, 16'h0001);
    acc = 1'b1;
    repeat (17) tick();
    acc = 1'b0;
    checks++; if (acc_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat got=%0d exp=15", acc_cnt); end
    checks++; if (lane_of(7) !== 16'h0011) begin errors++; $display("FAIL cnt_sat_sum got=%h exp=0011", lane_of(7)); end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    do_clear();
    acc = 1'b1;
    set_lanes(16'h0001, 16'h0001);
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(out_valid); end
    set_lanes(16'h0002, 16'h0002);
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(out_valid); end
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); pulses += int'(out_valid); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL merged_pulses got=%0d exp=1", pulses); end
    checks++; if (lane_of(4) !== 16'h0009) begin errors++; $display("FAIL merged_sum got=%h exp=0009", lane_of(4)); end
    checks++; if (acc_cnt !== 4'd6) begin errors++; $display("FAIL merged_acc_cnt got=%0d exp=6", acc_cnt); end
  endtask

  initial begin
    reset   = 1'b1;
    acc     = 1'b0;
    clear   = 1'b0;
    relu_en = 1'b0;
    psum_in = '0;
    repeat (2) tick();
    test_reset();
    test_burst9();
    test_relu();
    test_saturation();
    test_clear_acc();
    test_reset_mid_burst();
    test_cnt_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
